// File: rtl/parity_engine_if.sv
// Handshake/bus bundle for parity_engine: TX parity handshake, RX bit-serial
// input, error counter and mode controls.
interface parity_engine_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 parity_enable;
  logic [1:0]           parity_mode;
  logic                 tx_valid;
  logic [WIDTH-1:0]     tx_data;
  logic                 tx_ready;
  logic                 tx_par_valid;
  logic                 tx_par;
  logic                 tx_par_ack;
  logic                 rx_start;
  logic                 rx_bit_strobe;
  logic                 rx_bit;
  logic [WIDTH-1:0]     rx_data;
  logic                 rx_done;
  logic                 rx_par_err;
  logic                 err_clr;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output parity_enable, parity_mode, tx_valid, tx_data, tx_par_ack,
           rx_start, rx_bit_strobe, rx_bit, err_clr,
    input  tx_ready, tx_par_valid, tx_par, rx_data, rx_done, rx_par_err, err_cnt
  );

  modport slave (
    input  parity_enable, parity_mode, tx_valid, tx_data, tx_par_ack,
           rx_start, rx_bit_strobe, rx_bit, err_clr,
    output tx_ready, tx_par_valid, tx_par, rx_data, rx_done, rx_par_err, err_cnt
  );
endinterface

// File: rtl/parity_engine.sv
// UART parity engine: TX parity generation on a valid/ready handshake, RX
// bit-serial parity check with a saturating parity-error counter.
module parity_engine #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  parity_engine_if.slave  io_bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StData, StPar} rx_state_e;

  // Parity of a word given its XOR reduction and the latched mode/enable.
  function automatic logic f_parity(input logic en, input logic [1:0] mode, input logic red);
    logic p;
    unique case (mode)
      2'b00:   p = red;
      2'b01:   p = ~red;
      2'b10:   p = 1'b0;
      default: p = 1'b1;
    endcase
    return en & p;
  endfunction

  // TX path
  logic r_tx_par_valid, r_tx_par;
  logic w_tx_ready, w_tx_capture;

  assign w_tx_ready   = ~r_tx_par_valid | io_bus.tx_par_ack;
  assign w_tx_capture = io_bus.tx_valid & w_tx_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_par_valid <= 1'b0;
      r_tx_par       <= 1'b0;
    end else if (w_tx_capture) begin
      r_tx_par_valid <= 1'b1;
      r_tx_par       <= f_parity(io_bus.parity_enable, io_bus.parity_mode, ^io_bus.tx_data);
    end else if (io_bus.tx_par_ack) begin
      r_tx_par_valid <= 1'b0;
    end
  end

  // RX path
  rx_state_e        r_state, w_state_d;
  logic [CntW-1:0]  r_bit_cnt, w_bit_cnt_d;
  logic             r_acc, w_acc_d;
  logic [WIDTH-1:0] r_shift, w_shift_d, w_shift_in;
  logic             r_en, w_en_d;
  logic [1:0]       r_mode, w_mode_d;
  logic [WIDTH-1:0] r_rx_data, w_rx_data_d;
  logic             r_rx_done, w_rx_done_d;
  logic             r_rx_par_err, w_rx_par_err_d;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign w_shift_in = {io_bus.rx_bit, r_shift[WIDTH-1:1]};

  always_comb begin
    w_state_d      = r_state;
    w_bit_cnt_d    = r_bit_cnt;
    w_acc_d        = r_acc;
    w_shift_d      = r_shift;
    w_en_d         = r_en;
    w_mode_d       = r_mode;
    w_rx_data_d    = r_rx_data;
    w_rx_done_d    = 1'b0;
    w_rx_par_err_d = 1'b0;
    // A start bit always restarts the frame and swallows a coincident strobe.
    if (io_bus.rx_start) begin
      w_state_d   = StData;
      w_bit_cnt_d = '0;
      w_acc_d     = 1'b0;
      w_shift_d   = '0;
      w_en_d      = io_bus.parity_enable;
      w_mode_d    = io_bus.parity_mode;
    end else begin
      case (r_state)
        StData: begin
          if (io_bus.rx_bit_strobe) begin
            w_shift_d   = w_shift_in;
            w_acc_d     = r_acc ^ io_bus.rx_bit;
            w_bit_cnt_d = r_bit_cnt + CntW'(1);
            if (r_bit_cnt == CntW'(WIDTH - 1)) begin
              if (r_en) begin
                w_state_d = StPar;
              end else begin
                w_state_d   = StIdle;
                w_rx_done_d = 1'b1;
                w_rx_data_d = w_shift_in;
              end
            end
          end
        end
        StPar: begin
          if (io_bus.rx_bit_strobe) begin
            w_state_d      = StIdle;
            w_rx_done_d    = 1'b1;
            w_rx_data_d    = r_shift;
            w_rx_par_err_d = io_bus.rx_bit != f_parity(1'b1, r_mode, r_acc);
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_bit_cnt    <= '0;
      r_acc        <= 1'b0;
      r_shift      <= '0;
      r_en         <= 1'b0;
      r_mode       <= 2'b00;
      r_rx_data    <= '0;
      r_rx_done    <= 1'b0;
      r_rx_par_err <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_acc        <= w_acc_d;
      r_shift      <= w_shift_d;
      r_en         <= w_en_d;
      r_mode       <= w_mode_d;
      r_rx_data    <= w_rx_data_d;
      r_rx_done    <= w_rx_done_d;
      r_rx_par_err <= w_rx_par_err_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (io_bus.err_clr) begin
      r_err_cnt <= '0;
    end else if (r_rx_par_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign io_bus.tx_ready     = w_tx_ready;
  assign io_bus.tx_par_valid = r_tx_par_valid;
  assign io_bus.tx_par       = r_tx_par;
  assign io_bus.rx_data      = r_rx_data;
  assign io_bus.rx_done      = r_rx_done;
  assign io_bus.rx_par_err   = r_rx_par_err;
  assign io_bus.err_cnt      = r_err_cnt;

endmodule
